best_1ofn_cclut_pipe: RTL and testbench

//  Pipelined, parametrised best-1-of-N CLCT pattern sorter for the ccLUT finder.

---
 rtl/cclut_sort_pkg.sv | 40 ++++
 rtl/best_2of2_cclut_node.sv | 44 ++++
 rtl/best_1ofn_cclut_pipe.sv | 105 ++++++++++
 tb/tb_best_1ofn_cclut_pipe.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cclut_sort_pkg.sv
// Shared definitions for the ccLUT CLCT sorters: default widths, clog2, and the
// flat candidate record layout {prs, pat, cfeb_idx, key, carry} (carry in the LSBs).
package cclut_sort_pkg;

  localparam int unsigned DefaultMxpatb = 6;
  localparam int unsigned DefaultMxkeyb = 5;
  localparam int unsigned DefaultMxpatc = 11;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    int unsigned v;
    r = 0;
    v = (n > 0) ? n - 1 : 0;
    while (v > 0) begin
      v = v >> 1;
      r++;
    end
    return r;
  endfunction

  function automatic int unsigned rec_key_lsb(input int unsigned mxpatc);
    return mxpatc;
  endfunction

  function automatic int unsigned rec_idx_lsb(input int unsigned mxpatc, input int unsigned mxkeyb);
    return mxpatc + mxkeyb;
  endfunction

  function automatic int unsigned rec_pat_lsb(input int unsigned mxpatc, input int unsigned mxkeyb,
                                              input int unsigned mxcfebb);
    return mxpatc + mxkeyb + mxcfebb;
  endfunction

  // The prs (present) bit sits above pat so real channels always outrank pad leaves.
  function automatic int unsigned rec_prs_bit(input int unsigned mxpatc, input int unsigned mxkeyb,
                                              input int unsigned mxcfebb, input int unsigned mxpatb);
    return mxpatc + mxkeyb + mxcfebb + mxpatb;
  endfunction

endpackage

// File: rtl/best_2of2_cclut_node.sv
// One registered tournament node: picks the better of two candidate records (ties go left)
// and optionally tracks the runner-up of the combined subtree.
module best_2of2_cclut_node #(
  parameter int unsigned W        = 27,
  parameter int unsigned SortLsb  = 20,
  parameter bit          SecondEn = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] a_best,
  input  logic [W-1:0] a_sec,
  input  logic [W-1:0] b_best,
  input  logic [W-1:0] b_sec,
  output logic [W-1:0] best,
  output logic [W-1:0] sec
);

  logic b_wins;
  assign b_wins = b_best[W-1:SortLsb] > a_best[W-1:SortLsb];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) best <= '0;
    else       best <= b_wins ? b_best : a_best;
  end

  if (SecondEn) begin : g_second
    // Runner-up is the better of the loser's best and the winner's own runner-up;
    // the left-side contender always has the lower channel indices.
    logic [W-1:0] l_cand;
    logic [W-1:0] r_cand;
    assign l_cand = b_wins ? a_best : a_sec;
    assign r_cand = b_wins ? b_sec  : b_best;

    always_ff @(posedge clock or posedge reset) begin
      if (reset) sec <= '0;
      else       sec <= (r_cand[W-1:SortLsb] > l_cand[W-1:SortLsb]) ? r_cand : l_cand;
    end
  end else begin : g_no_second
    logic unused_sec_in;
    assign unused_sec_in = ^{a_sec, b_sec};
    assign sec = '0;
  end

endmodule

// File: rtl/best_1ofn_cclut_pipe.sv
// Pipelined best-1-of-N ccLUT CLCT sorter: registered binary tree, one stage per level.
// Define BEST_1OFN_SECOND_EN to add the runner-up outputs second_pat/second_key/second_carry.
module best_1ofn_cclut_pipe
  import cclut_sort_pkg::*;
#(
  parameter int unsigned NCFEB   = 7,
  parameter int unsigned MXPATB  = DefaultMxpatb,
  parameter int unsigned MXKEYB  = DefaultMxkeyb,
  parameter int unsigned MXPATC  = DefaultMxpatc,
  parameter int unsigned MXCFEBB = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [NCFEB*MXPATB-1:0]    pat_in,
  input  logic [NCFEB*MXKEYB-1:0]    key_in,
  input  logic [NCFEB*MXPATC-1:0]    carry_in,
  output logic                       out_valid,
  output logic [MXPATB-1:0]          best_pat,
  output logic [MXCFEBB+MXKEYB-1:0]  best_key,
  output logic [MXPATC-1:0]          best_carry
`ifdef BEST_1OFN_SECOND_EN
  ,
  output logic [MXPATB-1:0]          second_pat,
  output logic [MXCFEBB+MXKEYB-1:0]  second_key,
  output logic [MXPATC-1:0]          second_carry
`endif
);

  localparam int unsigned LAT     = clog2(NCFEB);
  localparam int unsigned NP      = 1 << LAT;
  localparam int unsigned KeyLsb  = rec_key_lsb(MXPATC);
  localparam int unsigned PatLsb  = rec_pat_lsb(MXPATC, MXKEYB, MXCFEBB);
  localparam int unsigned PrsBit  = rec_prs_bit(MXPATC, MXKEYB, MXCFEBB, MXPATB);
  localparam int unsigned W       = PrsBit + 1;
`ifdef BEST_1OFN_SECOND_EN
  localparam bit          SecondEn = 1'b1;
`else
  localparam bit          SecondEn = 1'b0;
`endif

  if (NCFEB < 2 || (1 << MXCFEBB) < NCFEB) begin : g_bad_cfg
    $error("best_1ofn_cclut_pipe: need NCFEB >= 2 and 2**MXCFEBB >= NCFEB");
  end

  // Heap-indexed tree: node n has children 2n and 2n+1, leaves at NP..2*NP-1.
  logic [W-1:0] best_t [1:2*NP-1];
  logic [W-1:0] sec_t  [1:2*NP-1];

  for (genvar i = 0; i < NP; i++) begin : g_leaf
    if (i < NCFEB) begin : g_real
      assign best_t[NP+i] = {1'b1, pat_in[i*MXPATB +: MXPATB], MXCFEBB'(i),
                             key_in[i*MXKEYB +: MXKEYB], carry_in[i*MXPATC +: MXPATC]};
    end else begin : g_pad
      assign best_t[NP+i] = '0;
    end
    assign sec_t[NP+i] = '0;
  end

  for (genvar n = 1; n < NP; n++) begin : g_node
    best_2of2_cclut_node #(
      .W        (W),
      .SortLsb  (PatLsb + 1),
      .SecondEn (SecondEn)
    ) u_node (
      .clock  (clock),
      .reset  (reset),
      .a_best (best_t[2*n]),
      .a_sec  (sec_t[2*n]),
      .b_best (best_t[2*n+1]),
      .b_sec  (sec_t[2*n+1]),
      .best   (best_t[n]),
      .sec    (sec_t[n])
    );
  end

  logic [LAT-1:0] vld_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
    end else begin
      vld_q[0] <= in_valid;
      for (int unsigned s = 1; s < LAT; s++) vld_q[s] <= vld_q[s-1];
    end
  end

  assign out_valid  = vld_q[LAT-1];
  assign best_pat   = best_t[1][PatLsb +: MXPATB];
  assign best_key   = best_t[1][KeyLsb +: MXCFEBB+MXKEYB];
  assign best_carry = best_t[1][MXPATC-1:0];

`ifdef BEST_1OFN_SECOND_EN
  assign second_pat   = sec_t[1][PatLsb +: MXPATB];
  assign second_key   = sec_t[1][KeyLsb +: MXCFEBB+MXKEYB];
  assign second_carry = sec_t[1][MXPATC-1:0];

  logic unused_bits;
  assign unused_bits = best_t[1][PrsBit] ^ sec_t[1][PrsBit];
`else
  logic unused_bits;
  assign unused_bits = ^{best_t[1][PrsBit], sec_t[1]};
`endif

endmodule

// File: tb/tb_best_1ofn_cclut_pipe.sv
// Directed bench for best_1ofn_cclut_pipe (NCFEB=7, LAT=3) with a scoreboard of expected winners.
module tb_best_1ofn_cclut_pipe;

  localparam int unsigned NCFEB   = 7;
  localparam int unsigned MXPATB  = 6;
  localparam int unsigned MXKEYB  = 5;
  localparam int unsigned MXPATC  = 11;
  localparam int unsigned MXCFEBB = 3;
  localparam int          LAT     = 3;

  logic                      clock = 1'b0;
  logic                      reset = 1'b1;
  logic                      in_valid = 1'b0;
  logic [NCFEB*MXPATB-1:0]   pat_in = '0;
  logic [NCFEB*MXKEYB-1:0]   key_in = '0;
  logic [NCFEB*MXPATC-1:0]   carry_in = '0;
  logic                      out_valid;
  logic [MXPATB-1:0]         best_pat;
  logic [MXCFEBB+MXKEYB-1:0] best_key;
  logic [MXPATC-1:0]         best_carry;
`ifdef BEST_1OFN_SECOND_EN
  logic [MXPATB-1:0]         second_pat;
  logic [MXCFEBB+MXKEYB-1:0] second_key;
  logic [MXPATC-1:0]         second_carry;
`endif

  best_1ofn_cclut_pipe #(
    .NCFEB   (NCFEB),
    .MXPATB  (MXPATB),
    .MXKEYB  (MXKEYB),
    .MXPATC  (MXPATC),
    .MXCFEBB (MXCFEBB)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .in_valid   (in_valid),
    .pat_in     (pat_in),
    .key_in     (key_in),
    .carry_in   (carry_in),
    .out_valid  (out_valid),
    .best_pat   (best_pat),
    .best_key   (best_key),
    .best_carry (best_carry)
`ifdef BEST_1OFN_SECOND_EN
    ,
    .second_pat   (second_pat),
    .second_key   (second_key),
    .second_carry (second_carry)
`endif
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [5:0]  pat;
    logic [7:0]  key;
    logic [10:0] carry;
    logic [5:0]  spat;
    logic [7:0]  skey;
    logic [10:0] scarry;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [5:0]  p [NCFEB];
  logic [4:0]  k [NCFEB];
  logic [10:0] c [NCFEB];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: scan channels in order, strict-greater on pat[5:1] keeps ties at the lowest index.
  function automatic exp_t model(input int due);
    exp_t e;
    int bi = 0;
    int si = -1;
    for (int i = 1; i < NCFEB; i++) if (p[i][5:1] > p[bi][5:1]) bi = i;
    for (int i = 0; i < NCFEB; i++)
      if (i != bi && (si < 0 || p[i][5:1] > p[si][5:1])) si = i;
    e.due    = due;
    e.pat    = p[bi];
    e.key    = {3'(bi), k[bi]};
    e.carry  = c[bi];
    e.spat   = p[si];
    e.skey   = {3'(si), k[si]};
    e.scarry = c[si];
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t e;
    logic exp_v;
    exp_v = (sb.size() > 0) && (sb[0].due == cyc);
    chk("out_valid", 32'(out_valid), 32'(exp_v));
    if (exp_v) begin
      e = sb.pop_front();
      chk("best_pat", 32'(best_pat), 32'(e.pat));
      chk("best_key", 32'(best_key), 32'(e.key));
      chk("best_carry", 32'(best_carry), 32'(e.carry));
`ifdef BEST_1OFN_SECOND_EN
      chk("second_pat", 32'(second_pat), 32'(e.spat));
      chk("second_key", 32'(second_key), 32'(e.skey));
      chk("second_carry", 32'(second_carry), 32'(e.scarry));
`endif
    end
  end

  task automatic send(input bit v);
    @(posedge clock);
    #1;
    in_valid = v;
    for (int i = 0; i < NCFEB; i++) begin
      pat_in[i*MXPATB +: MXPATB]   = p[i];
      key_in[i*MXKEYB +: MXKEYB]   = k[i];
      carry_in[i*MXPATC +: MXPATC] = c[i];
    end
    if (v) sb.push_back(model(cyc + LAT));
  endtask

  task automatic rand_kc();
    for (int i = 0; i < NCFEB; i++) begin
      k[i] = 5'($urandom);
      c[i] = 11'($urandom);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_pat"}, 32'(best_pat), 32'd0);
    chk({tag, "_key"}, 32'(best_key), 32'd0);
    chk({tag, "_carry"}, 32'(best_carry), 32'd0);
  endtask

  initial begin
    int sk1 [NCFEB] = '{3, 5, 2, 5, 1, 0, 4};
    int sk6 [NCFEB] = '{7, 7, 2, 1, 0, 0, 6};
    for (int i = 0; i < NCFEB; i++) begin
      p[i] = '0;
      k[i] = '0;
      c[i] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_zero("reset");
    @(posedge clock);
    #1 reset = 1'b0;

    // Sort keys {3,5,2,5,1,0,4}: ch1 wins the tie with ch3.
    rand_kc();
    for (int i = 0; i < NCFEB; i++) p[i] = {5'(sk1[i]), 1'($urandom)};
    send(1);
    send(0);

    // Equal sort keys differing only in the L/R bit: ch2 beats ch4.
    for (int i = 0; i < NCFEB; i++) p[i] = '0;
    p[2] = 6'h0A;
    p[4] = 6'h0B;
    rand_kc();
    send(1);
    send(0);
    send(0);

    // Ten back-to-back valids, winner rotates across channels.
    for (int n = 0; n < 10; n++) begin
      rand_kc();
      for (int i = 0; i < NCFEB; i++) p[i] = 6'($urandom_range(0, 6'h3D));
      p[n % NCFEB] = 6'h3E;
      send(1);
    end
    send(0);

    // All-zero patterns, then only ch6 nonzero.
    for (int i = 0; i < NCFEB; i++) p[i] = '0;
    rand_kc();
    send(1);
    p[6] = 6'h3F;
    rand_kc();
    send(1);
    send(0);
    send(0);

    // Random vectors.
    for (int n = 0; n < 6; n++) begin
      rand_kc();
      for (int i = 0; i < NCFEB; i++) p[i] = 6'($urandom);
      send(1);
    end
    repeat (LAT + 1) send(0);

    // Reset one cycle after a valid: the candidate must vanish.
    rand_kc();
    for (int i = 0; i < NCFEB; i++) p[i] = 6'($urandom_range(2, 63));
    send(1);
    @(posedge clock);
    #1;
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clock);
    chk_zero("rst_mid");
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (LAT + 1) send(0);
    rand_kc();
    for (int i = 0; i < NCFEB; i++) p[i] = 6'($urandom);
    send(1);

    // Keys {7,7,2,1,0,0,6}: best ch0, runner-up ch1.
    rand_kc();
    for (int i = 0; i < NCFEB; i++) p[i] = {5'(sk6[i]), 1'($urandom)};
    send(1);

    repeat (LAT + 2) send(0);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
